// File: rtl/chunk_subtractor.sv
// Multi-cycle unsigned subtractor: D = A - B over SEG-bit slices, one slice per clock.
// Optional CHUNK_SUB_ADD_EN adds an op input selecting A + B instead.
module chunk_subtractor #(
  parameter int ANCHO = 64,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef CHUNK_SUB_ADD_EN
  input  logic             op,
`endif
  input  logic [ANCHO-1:0] A,
  input  logic [ANCHO-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [ANCHO-1:0] D,
  output logic             borrow
);

  localparam int N     = ANCHO / SEG;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             done_q, done_d;
  logic             borrow_q, borrow_d;
  logic [ANCHO-1:0] d_q, d_d;

  logic [ANCHO-1:0] a_q, nb_q, res_q;
  logic             load, step;
  logic             start_sub, run_sub;
  logic [SEG:0]     slice_sum;
  logic [ANCHO+SEG-1:0] res_cat;
  logic [ANCHO-1:0] res_next;

`ifdef CHUNK_SUB_ADD_EN
  logic op_q;
  assign start_sub = ~op;
  assign run_sub   = ~op_q;
`else
  assign start_sub = 1'b1;
  assign run_sub   = 1'b1;
`endif

  // Operands shift right one slice per step, so slice 0 always holds the active slice;
  // the result fills from the top and is complete after N steps.
  assign slice_sum = {1'b0, a_q[SEG-1:0]} + {1'b0, nb_q[SEG-1:0]} + {{SEG{1'b0}}, carry_q};
  assign res_cat   = {slice_sum[SEG-1:0], res_q};
  assign res_next  = res_cat[ANCHO+SEG-1:SEG];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    done_d   = 1'b0;
    borrow_d = borrow_q;
    d_d      = d_q;
    load     = 1'b0;
    step     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = CALC;
          cnt_d   = '0;
          carry_d = start_sub;
        end
      end
      CALC: begin
        step    = 1'b1;
        carry_d = slice_sum[SEG];
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d  = IDLE;
          cnt_d    = '0;
          d_d      = res_next;
          borrow_d = run_sub ? ~slice_sum[SEG] : slice_sum[SEG];
          done_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      done_q   <= 1'b0;
      borrow_q <= 1'b0;
      d_q      <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      done_q   <= done_d;
      borrow_q <= borrow_d;
      d_q      <= d_d;
    end
  end

  // Working registers need no reset: they are always loaded before CALC reads them.
  always_ff @(posedge clk) begin
    if (load) begin
      a_q   <= A;
      nb_q  <= start_sub ? ~B : B;
      res_q <= '0;
`ifdef CHUNK_SUB_ADD_EN
      op_q  <= op;
`endif
    end else if (step) begin
      a_q   <= a_q >> SEG;
      nb_q  <= nb_q >> SEG;
      res_q <= res_next;
    end
  end

  assign busy   = (state_q == CALC);
  assign done   = done_q;
  assign D      = d_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_chunk_subtractor.sv
// Self-checking bench for chunk_subtractor: directed handshake/reset cases plus random
// operands against an arithmetic reference; add mode covered when CHUNK_SUB_ADD_EN is set.
module tb_chunk_subtractor;

  localparam int ANCHO = 64;
  localparam int SEG   = 8;
  localparam int N     = ANCHO / SEG;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             op;
  logic [ANCHO-1:0] A, B;
  logic             busy, done, borrow;
  logic [ANCHO-1:0] D;

  int checks;
  int errors;

  logic [ANCHO-1:0] exp_d;
  logic             exp_b;

  chunk_subtractor #(.ANCHO(ANCHO), .SEG(SEG)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
`ifdef CHUNK_SUB_ADD_EN
    .op     (op),
`endif
    .A      (A),
    .B      (B),
    .busy   (busy),
    .done   (done),
    .D      (D),
    .borrow (borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain wide arithmetic; bit ANCHO is the borrow (sub) or carry (add).
  function automatic logic [ANCHO:0] model(input logic [ANCHO-1:0] a, input logic [ANCHO-1:0] b,
                                           input logic o);
    if (o) return {1'b0, a} + {1'b0, b};
    else   return {1'b0, a} - {1'b0, b};
  endfunction

  task automatic chk(input string tag, input logic [ANCHO-1:0] obs, input logic [ANCHO-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction with cycle-exact handshake checks.
  task automatic run_op(input logic [ANCHO-1:0] a, input logic [ANCHO-1:0] b, input logic o,
                        input string tag);
    logic [ANCHO:0] r;
    r = model(a, b, o);
    A = a; B = b; op = o; start = 1'b1;
    tick();
    start = 1'b0;
    A = ~a; B = ~b;
    chk({tag, "_busy0"}, busy, 1);
    chk({tag, "_done0"}, done, 0);
    for (int e = 1; e < N; e++) begin
      tick();
      chk({tag, "_busy_mid"}, busy, 1);
      chk({tag, "_done_mid"}, done, 0);
      chk({tag, "_d_hold"}, D, exp_d);
    end
    tick();
    exp_d = r[ANCHO-1:0];
    exp_b = r[ANCHO];
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_D"}, D, exp_d);
    chk({tag, "_borrow"}, borrow, exp_b);
    tick();
    chk({tag, "_done_clr"}, done, 0);
    chk({tag, "_D_held"}, D, exp_d);
  endtask

  initial begin
    logic [ANCHO:0] r;
    logic [ANCHO-1:0] ra, rb, a2, b2, d1, d2;
    checks = 0; errors = 0;
    exp_d = '0; exp_b = 1'b0;
    rst_n = 1'b0; start = 1'b0; op = 1'b0; A = '0; B = '0;

    // Reset and quiet idle
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_D", D, 0);
    chk("rst_borrow", borrow, 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("idle_nodone", done, 0);
    end

    // Basic and boundary values
    run_op(64'd5, 64'd3, 1'b0, "5m3");
    run_op(64'd0, 64'd1, 1'b0, "0m1");
    run_op({ANCHO{1'b1}}, {ANCHO{1'b1}}, 1'b0, "ones");
    run_op(64'd3, 64'd5, 1'b0, "3m5");

    // Start while busy is ignored
    r = model(64'd10, 64'd4, 1'b0);
    A = 64'd10; B = 64'd4; start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e <= N; e++) begin
      if (e == 3) begin A = 64'd1; B = 64'd1; start = 1'b1; end
      else start = 1'b0;
      tick();
      if (e < N) begin
        chk("ign_busy", busy, 1);
        chk("ign_done", done, 0);
      end
    end
    start = 1'b0;
    exp_d = r[ANCHO-1:0]; exp_b = r[ANCHO];
    chk("ign_done_end", done, 1);
    chk("ign_D", D, 64'd6);
    chk("ign_borrow", borrow, 0);
    tick();
    chk("ign_idle_after", busy, 0);
    chk("ign_done_clr", done, 0);

    // Start held high across done: back-to-back with no gap
    ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
    a2 = {$urandom, $urandom}; b2 = {$urandom, $urandom};
    r = model(ra, rb, 1'b0); d1 = r[ANCHO-1:0];
    r = model(a2, b2, 1'b0); d2 = r[ANCHO-1:0];
    A = ra; B = rb; start = 1'b1;
    for (int e = 0; e <= 2 * N + 2; e++) begin
      tick();
      if (e == 2) begin A = 64'h0123_4567_89AB_CDEF; B = 64'h1; end
      if (e == N) begin
        chk("b2b_done1", done, 1);
        chk("b2b_D1", D, d1);
        A = a2; B = b2;
      end else if (e == N + 1) begin
        chk("b2b_busy2", busy, 1);
        chk("b2b_done_gap", done, 0);
      end else if (e == 2 * N + 1) begin
        chk("b2b_done2", done, 1);
        chk("b2b_D2", D, d2);
        start = 1'b0;
      end else if (e == 2 * N + 2) begin
        chk("b2b_idle", busy, 0);
        chk("b2b_done_clr", done, 0);
      end else begin
        chk("b2b_nodone", done, 0);
      end
    end
    exp_d = d2;

    // Asynchronous reset mid-operation
    A = 64'd100; B = 64'd1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_D", D, 0);
    chk("mid_rst_borrow", borrow, 0);
    exp_d = '0; exp_b = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("mid_rst_nodone", done, 0);
    end
    run_op(64'd100, 64'd1, 1'b0, "after_rst");

    // Random subtraction
    for (int i = 0; i < 20; i++) begin
      run_op({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, "rnd_sub");
    end

`ifdef CHUNK_SUB_ADD_EN
    run_op({ANCHO{1'b1}}, 64'd1, 1'b1, "add_wrap");
    for (int i = 0; i < 20; i++) begin
      run_op({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, "rnd_add");
      run_op({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, "rnd_mix_sub");
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
